// File: rtl/event_led_hub_pkg.sv
// Shared definitions for the event LED hub: FSM state encoding, channel-index
// width helper and the field layout of the LED display word.
package event_hub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hub_state_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Payload sits at the bottom of the LED word.
  localparam int LED_DATA_LSB = 0;

  // Channel index sits directly above the payload.
  function automatic int led_ch_lsb(input int data_w);
    return LED_DATA_LSB + data_w;
  endfunction

endpackage

// File: rtl/event_led_hub_if.sv
// Event source bundle: one valid/ready strobe pair per channel plus packed payloads.
interface event_led_hub_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);

  logic [NUM_CH-1:0]        ev_valid;
  logic [NUM_CH*DATA_W-1:0] ev_data;
  logic [NUM_CH-1:0]        ev_ready;

  modport master (output ev_valid, output ev_data, input ev_ready);
  modport slave  (input ev_valid, input ev_data, output ev_ready);

endinterface

// File: rtl/event_led_hub_fifo.sv
// Single-clock per-channel event FIFO. Pointers carry one extra wrap bit so
// full and empty are told apart without a separate occupancy counter.
module event_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              ovf_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign ovf_pulse = push && full;
  assign dout      = mem[rd_ptr[AW-1:0]];

  // Advance read/write pointers; a blocked push leaves the FIFO untouched.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Store accepted payloads.
  // NOTE: the storage array has no reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/event_led_hub.sv
// Multi-channel event collector driving the board LEDs: per-channel FIFOs,
// fixed-priority or round-robin arbitration, and a hold timer per shown event.
module event_led_hub
  import event_hub_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int WIDTH_LEDS  = 16,
  parameter int HOLD_CYCLES = 1000,
  parameter int ARB_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  event_led_hub_if.slave        ev,
  input  logic                  clr_ovf,
  output logic [NUM_CH-1:0]     ovf,
  output logic [WIDTH_LEDS-1:0] leds,
  output logic                  busy
);

  localparam int CH_W   = ch_w(NUM_CH);
  localparam int CH_LSB = led_ch_lsb(DATA_W);
  localparam int HCW    = $clog2(HOLD_CYCLES + 1);

  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD_CYCLES - 1);
  localparam logic [HCW-1:0]  HOLD_ONE  = HCW'(1);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0] CH_ONE    = CH_W'(1);

  hub_state_e              state;
  logic [HCW-1:0]          hold_cnt;
  logic [CH_W-1:0]         rr_ptr;
  logic [NUM_CH-1:0]       ovf_q;
  logic [WIDTH_LEDS-1:0]   leds_q;
  logic                    busy_q;

  logic [NUM_CH-1:0]       full;
  logic [NUM_CH-1:0]       empty;
  logic [NUM_CH-1:0]       ovf_pulse;
  logic [NUM_CH-1:0]       pop;
  logic [DATA_W-1:0]       head [NUM_CH];

  logic                    gnt_valid;
  logic [CH_W-1:0]         gnt_idx;
  logic [DATA_W-1:0]       gnt_data;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    event_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (ev.ev_valid[g]),
      .din       (ev.ev_data[g*DATA_W +: DATA_W]),
      .pop       (pop[g]),
      .dout      (head[g]),
      .full      (full[g]),
      .empty     (empty[g]),
      .ovf_pulse (ovf_pulse[g])
    );
  end

  // Ready is purely a function of registered FIFO pointers.
  assign ev.ev_ready = ~full;

  // Pick the channel to show: scan from the highest search position down so
  // the first candidate in search order is the last one written.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    int              idx;
    logic [CH_W-1:0] cand;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    cand      = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ARB_MODE == 0) begin
        idx = k;
      end else begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
      end
      cand = CH_W'(idx);
      if (!empty[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Pop the granted channel only on the IDLE-to-HOLD transition.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop[i] = (state == IDLE) && gnt_valid && (gnt_idx == CH_W'(i));
    end
  end

  assign gnt_data = head[gnt_idx];

  // Sticky overflow flags; a new overflow beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (clr_ovf ? '0 : ovf_q) | ovf_pulse;
    end
  end

  // Display FSM: grant and load the LED word in IDLE, count out the hold in HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      rr_ptr   <= '0;
      leds_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      leds_q[WIDTH_LEDS-1] <= |ovf_q;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            leds_q[LED_DATA_LSB +: DATA_W] <= gnt_data;
            leds_q[CH_LSB +: CH_W]         <= gnt_idx;
            hold_cnt                       <= '0;
            rr_ptr                         <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + CH_ONE;
            busy_q                         <= 1'b1;
            state                          <= HOLD;
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt + HOLD_ONE;
          if (hold_cnt == HOLD_LAST) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ovf  = ovf_q;
  assign leds = leds_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_event_led_hub.sv
// Directed bench for event_led_hub: a cycle table for fixed-priority display,
// overflow and clear behaviour, plus sequences for reset-in-hold and round-robin.
module tb_event_led_hub;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [3:0]  ovf0, ovf1;
  logic [15:0] leds0, leds1;
  logic        busy0, busy1;

  event_led_hub_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) if0 ();
  event_led_hub_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) if1 ();

  event_led_hub #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(4), .WIDTH_LEDS(16),
    .HOLD_CYCLES(4), .ARB_MODE(0)
  ) dut0 (
    .clk(clk), .rst(rst), .ev(if0), .clr_ovf(clr_ovf),
    .ovf(ovf0), .leds(leds0), .busy(busy0)
  );

  event_led_hub #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(4), .WIDTH_LEDS(16),
    .HOLD_CYCLES(4), .ARB_MODE(1)
  ) dut1 (
    .clk(clk), .rst(rst), .ev(if1), .clr_ovf(clr_ovf),
    .ovf(ovf1), .leds(leds1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        clr;
    int          n;
    logic [15:0] leds;
    logic        busy;
    logic [3:0]  ready;
    logic [3:0]  ovf;
  } vec_t;

  vec_t vecs[35];

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic        pb0 = 1'b0;
  logic        pb1 = 1'b0;
  logic [15:0] exp0[8];
  logic [15:0] exp1[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic c);
    if0.ev_valid = v;
    if0.ev_data  = d;
    if1.ev_valid = v;
    if1.ev_data  = d;
    clr_ovf      = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step one cycle and log each new display (busy rising) per DUT.
  task automatic tick();
    step();
    if (busy0 && !pb0) q0.push_back(leds0);
    if (busy1 && !pb1) q1.push_back(leds1);
    pb0 = busy0;
    pb1 = busy1;
  endtask

  task automatic wait_both(input int n, input string name);
    int c;
    c = 0;
    while ((q0.size() < n || q1.size() < n) && c < 200) begin
      tick();
      c++;
    end
    check(name, (q0.size() >= n && q1.size() >= n) ? 1 : 0, 1);
  endtask

  initial begin
    int busy_cnt;

    drive(4'b0, 32'h0, 1'b0);

    //                 valid    data          clr n  leds      busy ready ovf
    vecs[0]  = '{4'b0100, 32'h00A5_0000, 1'b0, 1, 16'h0000, 1'b0, 4'hF, 4'h0};
    vecs[1]  = '{4'b0000, 32'h0000_0000, 1'b0, 4, 16'h02A5, 1'b1, 4'hF, 4'h0};
    vecs[2]  = '{4'b0000, 32'h0000_0000, 1'b0, 2, 16'h02A5, 1'b0, 4'hF, 4'h0};
    vecs[3]  = '{4'b1010, 32'h1100_2200, 1'b0, 1, 16'h02A5, 1'b0, 4'hF, 4'h0};
    vecs[4]  = '{4'b0000, 32'h0000_0000, 1'b0, 4, 16'h0122, 1'b1, 4'hF, 4'h0};
    vecs[5]  = '{4'b0000, 32'h0000_0000, 1'b0, 1, 16'h0122, 1'b0, 4'hF, 4'h0};
    vecs[6]  = '{4'b0000, 32'h0000_0000, 1'b0, 4, 16'h0311, 1'b1, 4'hF, 4'h0};
    vecs[7]  = '{4'b0000, 32'h0000_0000, 1'b0, 1, 16'h0311, 1'b0, 4'hF, 4'h0};
    vecs[8]  = '{4'b0100, 32'h0033_0000, 1'b0, 1, 16'h0311, 1'b0, 4'hF, 4'h0};
    vecs[9]  = '{4'b0001, 32'h0000_00D0, 1'b0, 1, 16'h0233, 1'b1, 4'hF, 4'h0};
    vecs[10] = '{4'b0001, 32'h0000_00D1, 1'b0, 1, 16'h0233, 1'b1, 4'hF, 4'h0};
    vecs[11] = '{4'b0001, 32'h0000_00D2, 1'b0, 1, 16'h0233, 1'b1, 4'hF, 4'h0};
    vecs[12] = '{4'b0001, 32'h0000_00D3, 1'b0, 1, 16'h0233, 1'b1, 4'hE, 4'h0};
    vecs[13] = '{4'b0001, 32'h0000_00D4, 1'b0, 1, 16'h0233, 1'b0, 4'hE, 4'h1};
    vecs[14] = '{4'b0000, 32'h0000_0000, 1'b0, 4, 16'h80D0, 1'b1, 4'hF, 4'h1};
    vecs[15] = '{4'b0000, 32'h0000_0000, 1'b0, 1, 16'h80D0, 1'b0, 4'hF, 4'h1};
    vecs[16] = '{4'b0000, 32'h0000_0000, 1'b0, 4, 16'h80D1, 1'b1, 4'hF, 4'h1};
    vecs[17] = '{4'b0000, 32'h0000_0000, 1'b0, 1, 16'h80D1, 1'b0, 4'hF, 4'h1};
    vecs[18] = '{4'b0000, 32'h0000_0000, 1'b0, 4, 16'h80D2, 1'b1, 4'hF, 4'h1};
    vecs[19] = '{4'b0000, 32'h0000_0000, 1'b0, 1, 16'h80D2, 1'b0, 4'hF, 4'h1};
    vecs[20] = '{4'b0000, 32'h0000_0000, 1'b0, 4, 16'h80D3, 1'b1, 4'hF, 4'h1};
    vecs[21] = '{4'b0000, 32'h0000_0000, 1'b0, 1, 16'h80D3, 1'b0, 4'hF, 4'h1};
    vecs[22] = '{4'b0000, 32'h0000_0000, 1'b1, 1, 16'h80D3, 1'b0, 4'hF, 4'h0};
    vecs[23] = '{4'b0000, 32'h0000_0000, 1'b0, 1, 16'h00D3, 1'b0, 4'hF, 4'h0};
    vecs[24] = '{4'b0001, 32'h0000_00E0, 1'b0, 1, 16'h00D3, 1'b0, 4'hF, 4'h0};
    vecs[25] = '{4'b0001, 32'h0000_00E1, 1'b0, 1, 16'h00E0, 1'b1, 4'hF, 4'h0};
    vecs[26] = '{4'b0001, 32'h0000_00E2, 1'b0, 1, 16'h00E0, 1'b1, 4'hF, 4'h0};
    vecs[27] = '{4'b0001, 32'h0000_00E3, 1'b0, 1, 16'h00E0, 1'b1, 4'hF, 4'h0};
    vecs[28] = '{4'b0001, 32'h0000_00E4, 1'b0, 1, 16'h00E0, 1'b1, 4'hE, 4'h0};
    vecs[29] = '{4'b0001, 32'h0000_00E5, 1'b1, 1, 16'h00E0, 1'b0, 4'hE, 4'h1};
    vecs[30] = '{4'b0000, 32'h0000_0000, 1'b0, 1, 16'h80E1, 1'b1, 4'hF, 4'h1};
    vecs[31] = '{4'b0000, 32'h0000_0000, 1'b1, 1, 16'h80E1, 1'b1, 4'hF, 4'h0};
    vecs[32] = '{4'b0000, 32'h0000_0000, 1'b0, 2, 16'h00E1, 1'b1, 4'hF, 4'h0};
    vecs[33] = '{4'b0000, 32'h0000_0000, 1'b0, 1, 16'h00E1, 1'b0, 4'hF, 4'h0};
    vecs[34] = '{4'b0010, 32'h0000_7700, 1'b0, 1, 16'h00E2, 1'b1, 4'hF, 4'h0};

    // Reset state.
    repeat (3) step();
    check("rst_leds",  leds0, 16'h0000);
    check("rst_busy",  busy0, 1'b0);
    check("rst_ready", if0.ev_ready, 4'hF);
    check("rst_ovf",   ovf0, 4'h0);
    check("rst_rrptr", dut1.rr_ptr, 0);
    rst = 1'b1;

    // Fixed-priority cycle table on dut0.
    for (int r = 0; r < 35; r++) begin
      for (int j = 0; j < vecs[r].n; j++) begin
        if (j == 0) drive(vecs[r].valid, vecs[r].data, vecs[r].clr);
        else        drive(4'b0, 32'h0, 1'b0);
        step();
        check($sformatf("vec%0d.%0d leds", r, j),  leds0,        vecs[r].leds);
        check($sformatf("vec%0d.%0d busy", r, j),  busy0,        vecs[r].busy);
        check($sformatf("vec%0d.%0d ready", r, j), if0.ev_ready, vecs[r].ready);
        check($sformatf("vec%0d.%0d ovf", r, j),   ovf0,         vecs[r].ovf);
      end
    end
    drive(4'b0, 32'h0, 1'b0);

    // Reset while holding an event with three more queued.
    rst = 1'b0;
    step();
    check("midrst_leds",  leds0, 16'h0000);
    check("midrst_busy",  busy0, 1'b0);
    check("midrst_ready", if0.ev_ready, 4'hF);
    rst = 1'b1;
    busy_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (busy0) busy_cnt++;
    end
    check("midrst_no_replay_busy", busy_cnt, 0);
    check("midrst_no_replay_leds", leds0, 16'h0000);

    // Round-robin versus fixed priority from a fresh reset.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    pb0 = busy0;
    pb1 = busy1;

    exp0 = '{16'h00A0, 16'h00A1, 16'h01B0, 16'h01B1, 16'h02C2, 16'h03C3, 16'h00D0, 16'h01D1};
    exp1 = '{16'h00A0, 16'h01B0, 16'h00A1, 16'h01B1, 16'h02C2, 16'h03C3, 16'h00D0, 16'h01D1};

    drive(4'b0011, 32'h0000_B0A0, 1'b0);
    tick();
    drive(4'b0011, 32'h0000_B1A1, 1'b0);
    tick();
    drive(4'b0000, 32'h0, 1'b0);
    wait_both(4, "rr_wait4");

    drive(4'b1100, 32'hC3C2_0000, 1'b0);
    tick();
    drive(4'b0000, 32'h0, 1'b0);
    wait_both(6, "rr_wait6");
    check("rr_ptr_wrap", dut1.rr_ptr, 0);

    drive(4'b0011, 32'h0000_D1D0, 1'b0);
    tick();
    drive(4'b0000, 32'h0, 1'b0);
    wait_both(8, "rr_wait8");

    for (int i = 0; i < 8; i++) begin
      check($sformatf("fixed_order%0d", i), (i < q0.size()) ? q0[i] : 16'hxxxx, exp0[i]);
      check($sformatf("rr_order%0d", i),    (i < q1.size()) ? q1[i] : 16'hxxxx, exp1[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
